// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states and access-size codes.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/lsu_ext.sv
// Load path: shift the memory word down to the accessed bytes, then sign- or
// zero-extend from the top bit of the access size.
module lsu_ext import lsu_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  offset,
    input  logic [1:0]        size,
    input  logic              ld_signed,
    output logic [DATA_W-1:0] ext
);

    localparam int IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sh;
    logic [IDX_W-1:0]  msb;
    logic              sbit;

    always_comb begin
        sh = data >> {offset, 3'b000};
        case (size)
            SZ_B:    msb = IDX_W'(7);
            SZ_H:    msb = IDX_W'(15);
            SZ_W:    msb = IDX_W'(31);
            default: msb = IDX_W'(DATA_W - 1);
        endcase
        sbit = ld_signed & sh[msb];
        for (int i = 0; i < DATA_W; i++)
            ext[i] = (i <= int'(msb)) ? sh[i] : sbit;
    end

endmodule

// File: rtl/lsu_bus.sv
// Single-outstanding load/store unit bridging an operation handshake to a
// word-wide memory request/response bus, with alignment checks and a timeout.
module lsu_bus import lsu_pkg::*; #(
    parameter int   ADDR_W  = 32,
    parameter int   DATA_W  = 32,
    parameter int   TIMEOUT = 255,
    localparam int  STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ren,
    input  logic              wen,
    input  logic              ld_signed,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err
);

    localparam int OFF_W = $clog2(STRB_W);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             state, state_nxt;
    logic               ld_q, st_q, sgn_q;
    logic [1:0]         size_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  ld_data;
    logic [OFF_W-1:0]   off;
    logic [STRB_W-1:0]  strb_base;
    logic [3:0]         size_oh;
    logic [2:0]         amask;
    logic               hs, nop, misal, timed_out;

    assign hs        = in_valid & in_ready;
    assign nop       = ~ren & ~wen;
    assign size_oh   = 4'b0001 << size;
    assign amask     = 3'(size_oh - 4'd1);
    assign misal     = ((addr[2:0] & amask) != 3'b000) || (size == SZ_D && DATA_W == 32);
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    // Ready outputs are gated by reset so every output reads 0 while held in reset.
    assign in_ready      = rst && state == IDLE;
    assign mem_rsp_ready = rst && (state == WAIT || state == IDLE);
    assign out_valid     = state == DONE;
    assign mem_req_valid = state == REQ;

    assign off           = addr_q[OFF_W-1:0];
    assign mem_req_we    = st_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign mem_req_wdata = wdata_q << {off, 3'b000};
    assign mem_req_wstrb = st_q ? (strb_base << off) : '0;

    always_comb begin
        case (size_q)
            SZ_B:    strb_base = STRB_W'(1);
            SZ_H:    strb_base = STRB_W'(3);
            SZ_W:    strb_base = STRB_W'(15);
            default: strb_base = '1;
        endcase
    end

    lsu_ext #(.DATA_W(DATA_W)) u_ext (
        .data      (mem_rsp_data),
        .offset    (off),
        .size      (size_q),
        .ld_signed (sgn_q),
        .ext       (ld_data)
    );

    // A timeout in REQ wins over a late mem_req_ready so the counter can never
    // run past TIMEOUT; in WAIT a coincident response wins over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs) state_nxt = (nop || misal) ? DONE : REQ;
            REQ:  if (timed_out) state_nxt = DONE;
                  else if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_rsp_valid || timed_out) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ld_q    <= ren;
                st_q    <= wen & ~ren;
                sgn_q   <= ld_signed;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= '0;
                rdata   <= '0;
                err     <= ~nop & misal;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (state == WAIT && mem_rsp_valid) begin
                    rdata <= ld_q ? ld_data : '0;
                    err   <= mem_rsp_err;
                end else if (timed_out) begin
                    rdata <= '0;
                    err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: two instances (long and short timeout) share
// stimulus; a per-op reference model drives a compare process every cycle.
module tb_lsu_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    bit          sel = 1'b0;
    logic        in_valid = 0, ren = 0, wen = 0, ld_signed = 0, out_ready = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0;
    logic [31:0] mem_rsp_data = 0;

    logic        a_in_ready, a_out_valid, a_err, a_req_valid, a_req_we, a_rsp_ready;
    logic [31:0] a_rdata, a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        b_in_ready, b_out_valid, b_err, b_req_valid, b_req_we, b_rsp_ready;
    logic [31:0] b_rdata, b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;

    wire         m_in_ready  = sel ? b_in_ready  : a_in_ready;
    wire         m_out_valid = sel ? b_out_valid : a_out_valid;
    wire         m_err       = sel ? b_err       : a_err;
    wire         m_req_valid = sel ? b_req_valid : a_req_valid;
    wire         m_req_we    = sel ? b_req_we    : a_req_we;
    wire         m_rsp_ready = sel ? b_rsp_ready : a_rsp_ready;
    wire  [31:0] m_rdata     = sel ? b_rdata     : a_rdata;
    wire  [31:0] m_req_addr  = sel ? b_req_addr  : a_req_addr;
    wire  [31:0] m_req_wdata = sel ? b_req_wdata : a_req_wdata;
    wire  [3:0]  m_req_wstrb = sel ? b_req_wstrb : a_req_wstrb;

    always #5 clk = ~clk;

    lsu_bus dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .ren(ren), .wen(wen), .ld_signed(ld_signed), .size(size), .addr(addr), .wdata(wdata),
        .out_valid(a_out_valid), .out_ready(out_ready), .rdata(a_rdata), .err(a_err),
        .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(a_req_we),
        .mem_req_addr(a_req_addr), .mem_req_wdata(a_req_wdata), .mem_req_wstrb(a_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(a_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    lsu_bus #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .ren(ren), .wen(wen), .ld_signed(ld_signed), .size(size), .addr(addr), .wdata(wdata),
        .out_valid(b_out_valid), .out_ready(out_ready), .rdata(b_rdata), .err(b_err),
        .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(b_req_we),
        .mem_req_addr(b_req_addr), .mem_req_wdata(b_req_wdata), .mem_req_wstrb(b_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(b_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference expectations for the operation in flight.
    bit          exp_noreq, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;

    task automatic model(input bit r, input bit w, input bit sg, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                         input bit rerr, input bit to);
        longint nb, off, v, m;
        bit ld, st, mis;
        nb  = longint'(1) << sz;
        off = longint'(a) % 4;
        ld  = r;
        st  = w && !r;
        mis = (longint'(a) % nb != 0) || sz == 2'd3;
        exp_noreq = !(ld || st) || mis;
        exp_we    = st;
        exp_addr  = a - 32'(off);
        exp_wstrb = st ? 4'(((longint'(1) << nb) - 1) << off) : 4'h0;
        exp_wdata = 32'(longint'(wd) << (8 * off));
        if (!(ld || st))   begin exp_rdata = 0; exp_err = 0;    end
        else if (mis)      begin exp_rdata = 0; exp_err = 1;    end
        else if (to)       begin exp_rdata = 0; exp_err = 1;    end
        else if (st)       begin exp_rdata = 0; exp_err = rerr; end
        else begin
            m = longint'(1) << (8 * nb);
            v = (longint'(rsp) >> (8 * off)) % m;
            if (sg && v >= m / 2) v = v - m;
            exp_rdata = 32'(v);
            exp_err   = rerr;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (exp_noreq) chk("no_req", m_req_valid, 0);
            else if (m_req_valid) begin
                chk("req_addr", m_req_addr, exp_addr);
                chk("req_we", m_req_we, exp_we);
                chk("req_wstrb", m_req_wstrb, exp_wstrb);
                if (exp_we) chk("req_wdata", m_req_wdata, exp_wdata);
            end
            if (m_out_valid) begin
                chk("rdata", m_rdata, exp_rdata);
                chk("err", m_err, exp_err);
            end
        end
    end

    bit          saw_req;
    int          last_lat;
    logic [31:0] last_rdata, last_req_addr, last_req_wdata;
    logic [3:0]  last_req_wstrb;
    logic        last_err;

    task automatic run_op(input bit s, input bit r, input bit w, input bit sg, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rsp,
                          input bit rerr, input int req_dly, input int rsp_dly, input bit respond);
        int acc;
        sel = s;
        model(r, w, sg, sz, a, wd, rsp, rerr, !respond);
        saw_req = 0; last_lat = -1; acc = 0;
        @(posedge clk); #1;
        in_valid = 1; ren = r; wen = w; ld_signed = sg; size = sz; addr = a; wdata = wd;
        @(negedge clk);
        chk("in_ready", m_in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0; ren = 0; wen = 0; ld_signed = 0; size = 0; addr = 0; wdata = 0;
        for (int c = 1; c <= 40; c++) begin
            mem_req_ready = (c > req_dly);
            mem_rsp_valid = respond && acc != 0 && (c == acc + 1 + rsp_dly);
            mem_rsp_data  = rsp;
            mem_rsp_err   = rerr;
            @(negedge clk);
            if (m_req_valid) begin
                saw_req = 1; last_req_addr = m_req_addr;
                last_req_wdata = m_req_wdata; last_req_wstrb = m_req_wstrb;
            end
            if (m_req_valid && mem_req_ready && acc == 0) acc = c;
            if (m_out_valid) begin
                last_lat = c; last_rdata = m_rdata; last_err = m_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (last_lat < 0) chk("out_valid_bound", 0, 1);
        @(posedge clk); #1;
        mem_rsp_valid = 0; mem_req_ready = 0; out_ready = 1;
        @(negedge clk);
        chk("done_hold", m_out_valid, 1);
        @(posedge clk); #1;
        out_ready = 0;
        @(negedge clk);
        chk("done_release", m_out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_noreq = 1;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", m_in_ready, 0);
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_req_valid", m_req_valid, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_err", m_err, 0);
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        chk("post_rst_in_ready", m_in_ready, 1);

        // lb signed, byte 3
        run_op(0, 1, 0, 1, 2'd0, 32'h1003, 0, 32'h80FF_1234, 0, 0, 0, 1);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_err", last_err, 0);
        chk("lb_lat", last_lat, 3);

        // sh upper half
        run_op(0, 0, 1, 0, 2'd1, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 0, 1);
        chk("sh_wstrb", last_req_wstrb, 4'b1100);
        chk("sh_wdata", last_req_wdata, 32'hBEEF_0000);
        chk("sh_addr", last_req_addr, 32'h2000);
        chk("sh_rdata", last_rdata, 0);

        // misaligned lw
        run_op(0, 1, 0, 0, 2'd2, 32'h3001, 0, 0, 0, 0, 0, 1);
        chk("lwmis_noreq", saw_req, 0);
        chk("lwmis_err", last_err, 1);
        chk("lwmis_lat", last_lat, 1);

        // more load/store patterns
        run_op(0, 1, 0, 0, 2'd1, 32'h1002, 0, 32'h80FF_1234, 0, 0, 0, 1);
        chk("lhu_rdata", last_rdata, 32'h0000_80FF);
        run_op(0, 1, 0, 1, 2'd1, 32'h1000, 0, 32'h1234_8001, 0, 0, 0, 1);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        run_op(0, 1, 0, 1, 2'd2, 32'h1004, 0, 32'hDEAD_BEEF, 0, 0, 0, 1);
        chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        run_op(0, 0, 1, 0, 2'd0, 32'h4001, 32'h0000_0055, 0, 0, 0, 0, 1);
        chk("sb_wstrb", last_req_wstrb, 4'b0010);
        chk("sb_wdata", last_req_wdata, 32'h0000_5500);
        run_op(0, 0, 1, 0, 2'd2, 32'h0010, 32'h1122_3344, 0, 0, 0, 0, 1);
        chk("sw_wstrb", last_req_wstrb, 4'b1111);

        // no-op, both ren+wen, dword on 32-bit bus
        run_op(0, 0, 0, 0, 2'd2, 32'h0008, 0, 0, 0, 0, 0, 1);
        chk("nop_noreq", saw_req, 0);
        chk("nop_err", last_err, 0);
        run_op(0, 1, 1, 0, 2'd2, 32'h1008, 32'hFFFF_FFFF, 32'hCAFE_F00D, 0, 0, 0, 1);
        chk("rw_rdata", last_rdata, 32'hCAFE_F00D);
        run_op(0, 1, 0, 0, 2'd3, 32'h0000, 0, 0, 0, 0, 0, 1);
        chk("ld_mis_err", last_err, 1);

        // long request stall then error response
        run_op(0, 1, 0, 0, 2'd2, 32'h0020, 0, 32'h1111_2222, 1, 10, 0, 1);
        chk("stall_err", last_err, 1);
        chk("stall_lat", last_lat, 13);

        // short-timeout instance: no response
        run_op(1, 1, 0, 0, 2'd2, 32'h0030, 0, 0, 0, 0, 0, 0);
        chk("to_err", last_err, 1);
        chk("to_rdata", last_rdata, 0);
        chk("to_lat", last_lat, 6);
        @(posedge clk); #1;
        mem_rsp_valid = 1; mem_rsp_data = 32'h7777_7777; mem_rsp_err = 1;
        @(negedge clk);
        chk("drop_rsp_ready", m_rsp_ready, 1);
        @(posedge clk); #1;
        mem_rsp_valid = 0; mem_rsp_err = 0;
        @(negedge clk);
        chk("drop_no_out", m_out_valid, 0);
        run_op(1, 1, 0, 0, 2'd2, 32'h0040, 0, 32'h0BAD_F00D, 0, 0, 0, 1);
        chk("after_to_rdata", last_rdata, 32'h0BAD_F00D);
        chk("after_to_lat", last_lat, 3);
        // response coincides with timeout: response wins
        run_op(1, 1, 0, 0, 2'd0, 32'h0041, 0, 32'h0000_A500, 0, 0, 3, 1);
        chk("race_rdata", last_rdata, 32'h0000_00A5);
        chk("race_err", last_err, 0);
        chk("race_lat", last_lat, 6);

        // reset while in WAIT
        sel = 0;
        model(1, 0, 0, 2'd2, 32'h0500, 0, 0, 0, 1);
        @(posedge clk); #1;
        in_valid = 1; ren = 1; size = 2'd2; addr = 32'h0500;
        @(posedge clk); #1;
        in_valid = 0; ren = 0; mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        @(negedge clk);
        chk("wait_rsp_ready", m_rsp_ready, 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mrst_out_valid", m_out_valid, 0);
        chk("mrst_req_valid", m_req_valid, 0);
        chk("mrst_in_ready", m_in_ready, 0);
        chk("mrst_rsp_ready", m_rsp_ready, 0);
        chk("mrst_req_addr", m_req_addr, 0);
        chk("mrst_rdata", m_rdata, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("mrst_in_ready_rel", m_in_ready, 1);
        run_op(0, 1, 0, 0, 2'd0, 32'h0602, 0, 32'h00C3_0000, 0, 0, 0, 1);
        chk("mrst_next_rdata", last_rdata, 32'h0000_00C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
